// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - digit-serial subtractor, a - b - borrow_in over WIDTH bits
// LSB digit first; the borrow ripples through a register between digits.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic             borrow_q, borrow_d, bout_q, bout_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT:0]   slice;
  logic [WIDTH-1:0] res_sh;
  logic             last;

  // Operands shift right so the active digit always sits in the low bits;
  // the MSBs are kept aside for the overflow decision.
  always_comb begin
    slice  = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow_q};
    res_sh = (res_q >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
    last   = (cnt_q == CW'(N - 1));
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d      = a;
          b_d      = b;
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
          borrow_d = borrow_in;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        borrow_d = slice[DIGIT];
        res_d    = res_sh;
        cnt_d    = cnt_q + 1'b1;
        if (last) begin
          diff_d  = res_sh;
          bout_d  = slice[DIGIT];
          ovf_d   = (a_msb_q != b_msb_q) && (res_sh[WIDTH-1] != a_msb_q);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Status decoded straight from state so an async reset clears it at once.
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor (DIGIT=1 and DIGIT=4)
module tb_serial_subtractor;

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, start4 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, a4 = '0, b4 = '0;
  logic       bin8 = 1'b0, bin4 = 1'b0;
  logic       busy8, done8, bo8, ov8, busy4, done4, bo4, ov4;
  logic [7:0] diff8, diff4;

  int   checks = 0;
  int   errors = 0;
  int   dones8 = 0;
  exp_t q8[$];
  exp_t q4[$];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .borrow_in(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8), .overflow(ov8)
  );

  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .borrow_in(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4), .overflow(ov4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    logic [8:0] full;
    exp_t       e;
    full = {1'b0, a} - {1'b0, b} - {8'd0, bin};
    e.d  = full[7:0];
    e.bo = full[8];
    e.ov = (a[7] != b[7]) && (full[7] != a[7]);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (done8) begin
        exp_t e;
        dones8++;
        if (q8.size() == 0) chk("done8_unexpected", 1, 0);
        else begin
          e = q8.pop_front();
          chk("diff8", diff8, e.d);
          chk("borrow8", bo8, e.bo);
          chk("ovf8", ov8, e.ov);
        end
      end
      if (done4) begin
        exp_t e;
        if (q4.size() == 0) chk("done4_unexpected", 1, 0);
        else begin
          e = q4.pop_front();
          chk("diff4", diff4, e.d);
          chk("borrow4", bo4, e.bo);
          chk("ovf4", ov4, e.ov);
        end
      end
    end
  end

  // Called at a negedge; returns at the following negedge with start released.
  task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic bin, input bit push);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    if (push) q8.push_back(model(a, b, bin));
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_done8(input logic [7:0] hold, output int bc);
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      if (done8) return;
      if (busy8) begin
        bc++;
        chk("diff8_hold", diff8, hold);
      end
      @(negedge clk);
    end
    chk("done8_timeout", 0, 1);
  endtask

  task automatic op4(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int bc;
    a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
    q4.push_back(model(a, b, bin));
    @(negedge clk);
    start4 = 1'b0;
    bc = 0;
    for (int i = 0; i < 40 && !done4; i++) begin
      if (busy4) bc++;
      @(negedge clk);
    end
    chk("busy4_cycles", bc, 2);
    chk("done4_seen", done4, 1);
    @(negedge clk);
    chk("done4_pulse_width", done4, 0);
  endtask

  initial begin
    int  bc;
    int  d0;
    time t1, t2;

    #1;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_diff", diff8, 0);
    chk("rst_borrow", bo8, 0);
    chk("rst_ovf", ov8, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_diff4", diff4, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    start_op8(8'h05, 8'h03, 1'b0, 1'b1);
    wait_done8(8'h00, bc);
    chk("busy8_cycles", bc, 8);
    @(negedge clk);
    chk("done8_pulse_width", done8, 0);

    start_op8(8'h00, 8'h01, 1'b0, 1'b1);
    wait_done8(8'h02, bc);
    @(negedge clk);
    start_op8(8'h80, 8'h01, 1'b0, 1'b1);
    wait_done8(8'hFF, bc);
    @(negedge clk);
    start_op8(8'h7F, 8'hFF, 1'b0, 1'b1);
    wait_done8(8'h7F, bc);
    @(negedge clk);
    start_op8(8'h00, 8'h00, 1'b1, 1'b1);
    wait_done8(8'h80, bc);
    @(negedge clk);

    op4(8'h10, 8'h01, 1'b1);
    op4(8'h00, 8'hFF, 1'b1);
    op4(8'hA5, 8'h3C, 1'b0);

    // A start pulse during RUN must be ignored.
    d0 = dones8;
    start_op8(8'h09, 8'h04, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(8'hFF, bc);
    repeat (12) @(negedge clk);
    chk("ignored_start_dones", dones8 - d0, 1);

    // Back-to-back: new start presented during the DONE cycle.
    start_op8(8'h09, 8'h04, 1'b0, 1'b1);
    wait_done8(8'h05, bc);
    t1 = $time;
    start_op8(8'h01, 8'h02, 1'b0, 1'b1);
    chk("b2b_busy_no_idle", busy8, 1);
    wait_done8(8'h05, bc);
    t2 = $time;
    chk("b2b_gap_cycles", 32'((t2 - t1) / 10), 9);
    @(negedge clk);

    // Asynchronous reset between edges, mid-RUN.
    start_op8(8'h40, 8'h01, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy8, 0);
    chk("arst_done", done8, 0);
    chk("arst_diff", diff8, 0);
    chk("arst_borrow", bo8, 0);
    chk("arst_ovf", ov8, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    d0 = dones8;
    repeat (12) @(negedge clk);
    chk("arst_no_done", dones8 - d0, 0);

    start_op8(8'h05, 8'h03, 1'b0, 1'b1);
    wait_done8(8'h00, bc);
    chk("post_rst_busy_cycles", bc, 8);
    repeat (2) @(negedge clk);

    chk("q8_drained", q8.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
